// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/serial_sub_if.sv
// Operand/result handshake bundle for serial_sub.
interface serial_sub_if #(
   parameter int unsigned W = 8
) ();

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] m;
   logic [W-1:0] s;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         borrow;
   logic         ovf;

   modport slave (
      input  in_valid, m, s, out_ready,
      output in_ready, out_valid, diff, borrow, ovf
   );

   modport master (
      output in_valid, m, s, out_ready,
      input  in_ready, out_valid, diff, borrow, ovf
   );

endinterface

// File: rtl/full_sub.sv
// One-bit full subtractor: d = x - y - bin, bout set when the bit underflows.
module full_sub (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = x ^ y ^ bin;
   assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial W-bit subtractor: diff = m - s, one bit per cycle, LSB first.
module serial_sub
   import serial_sub_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   serial_sub_if.slave  bus
);

   localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

   state_e          state_q, state_d;
   logic [W-1:0]    m_sh_q, m_sh_d;
   logic [W-1:0]    s_sh_q, s_sh_d;
   logic [W-1:0]    res_q, res_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            br_q, br_d;
   logic            borrow_q, borrow_d;
   logic            ovf_q, ovf_d;
   logic            d_bit, br_nxt, last_bit, accept;

   full_sub u_cell (
      .x    (m_sh_q[0]),
      .y    (s_sh_q[0]),
      .bin  (br_q),
      .d    (d_bit),
      .bout (br_nxt)
   );

   assign last_bit = (cnt_q == CW'(W - 1));
   assign accept   = (state_q == IDLE) && bus.in_valid;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.in_valid)  state_d = RUN;
         RUN:     if (last_bit)      state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake decode and datapath next values
   always_comb begin
      bus.in_ready  = (state_q == IDLE);
      bus.out_valid = (state_q == DONE);
      m_sh_d   = m_sh_q;
      s_sh_d   = s_sh_q;
      res_d    = res_q;
      cnt_d    = cnt_q;
      br_d     = br_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;
      if (accept) begin
         m_sh_d   = bus.m;
         s_sh_d   = bus.s;
         res_d    = '0;
         cnt_d    = '0;
         br_d     = 1'b0;
         borrow_d = 1'b0;
         ovf_d    = 1'b0;
      end else if (state_q == RUN) begin
         m_sh_d = m_sh_q >> 1;
         s_sh_d = s_sh_q >> 1;
         res_d  = (res_q >> 1) | (W'(d_bit) << (W - 1));
         br_d   = br_nxt;
         cnt_d  = cnt_q + CW'(1);
         // Overflow is the carry into the sign bit differing from the carry out.
         if (last_bit) begin
            borrow_d = br_nxt;
            ovf_d    = br_q ^ br_nxt;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_sh_q   <= '0;
         s_sh_q   <= '0;
         res_q    <= '0;
         cnt_q    <= '0;
         br_q     <= 1'b0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         m_sh_q   <= m_sh_d;
         s_sh_q   <= s_sh_d;
         res_q    <= res_d;
         cnt_q    <= cnt_d;
         br_q     <= br_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.diff   = res_q;
   assign bus.borrow = borrow_q;
   assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_serial_sub.sv
// Bench for serial_sub: W=8 and W=1 instances checked against an arithmetic model.
module tb_serial_sub;

   typedef struct packed {
      logic [7:0] d;
      logic       b;
      logic       o;
   } res_t;

   logic clk;
   logic rst_n;

   serial_sub_if #(.W(8)) bus8 ();
   serial_sub_if #(.W(1)) bus1 ();

   serial_sub #(.W(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
   serial_sub #(.W(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   logic busy [2];
   int   acc [2];
   res_t exp_r [2];
   res_t last_r [2];
   int   nres [2];
   int   acc_log [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Result of m - s on w-bit operands, from plain integer arithmetic.
   function automatic res_t model(input int w, input logic [7:0] mm, input logic [7:0] ss);
      res_t r;
      int mask = (1 << w) - 1;
      int a    = int'(mm) & mask;
      int b    = int'(ss) & mask;
      int dv   = (a - b) & mask;
      int sa   = (a >> (w - 1)) & 1;
      int sb   = (b >> (w - 1)) & 1;
      int sd   = (dv >> (w - 1)) & 1;
      r.d = 8'(dv);
      r.b = (a < b);
      r.o = (sa != sb) && (sd != sa);
      return r;
   endfunction

   task automatic step(input int i, input int w, input logic rstn, input logic iv,
                       input logic ir, input logic [7:0] mm, input logic [7:0] ss,
                       input logic ov, input logic ordy, input logic [7:0] df,
                       input logic br, input logic of);
      logic was_busy;
      logic exp_ov;
      if (!rstn) begin
         chk($sformatf("w%0d_reset_outputs", w), {ov, df, br, of}, 32'd0);
         chk($sformatf("w%0d_reset_in_ready", w), ir, 32'd1);
         busy[i] = 1'b0;
      end else begin
         was_busy = busy[i];
         exp_ov   = was_busy && ((cyc - acc[i]) >= (w + 1));
         chk($sformatf("w%0d_in_ready", w), ir, !was_busy);
         chk($sformatf("w%0d_out_valid", w), ov, exp_ov);
         if (exp_ov) begin
            chk($sformatf("w%0d_result", w), {df, br, of}, exp_r[i]);
            if (ordy) begin
               busy[i]   = 1'b0;
               last_r[i] = {df, br, of};
               nres[i]++;
            end
         end
         if (!was_busy && iv) begin
            exp_r[i] = model(w, mm, ss);
            busy[i]  = 1'b1;
            acc[i]   = cyc;
            if (i == 0) acc_log.push_back(cyc);
         end
      end
   endtask

   // Single compare process: every negedge, both instances against the model.
   always @(negedge clk) begin
      cyc++;
      step(0, 8, rst_n, bus8.in_valid, bus8.in_ready, bus8.m, bus8.s,
           bus8.out_valid, bus8.out_ready, bus8.diff, bus8.borrow, bus8.ovf);
      step(1, 1, rst_n, bus1.in_valid, bus1.in_ready, {7'b0, bus1.m}, {7'b0, bus1.s},
           bus1.out_valid, bus1.out_ready, {7'b0, bus1.diff}, bus1.borrow, bus1.ovf);
   end

   task automatic drive(input int i, input logic iv, input logic [7:0] mm, input logic [7:0] ss);
      if (i == 0) begin
         bus8.in_valid = iv; bus8.m = mm; bus8.s = ss;
      end else begin
         bus1.in_valid = iv; bus1.m = mm[0]; bus1.s = ss[0];
      end
   endtask

   function automatic logic get_ir(input int i);
      return (i == 0) ? bus8.in_ready : bus1.in_ready;
   endfunction

   // Present operands until accepted; optionally keep in_valid high afterwards.
   task automatic send(input int i, input logic [7:0] mm, input logic [7:0] ss, input bit drop);
      bit ok = 1'b0;
      drive(i, 1'b1, mm, ss);
      for (int n = 0; n < 64; n++) begin
         @(negedge clk);
         if (get_ir(i)) begin ok = 1'b1; break; end
      end
      chk("accept_wait", ok, 32'd1);
      @(posedge clk);
      #1;
      if (drop) drive(i, 1'b0, mm, ss);
   endtask

   task automatic wait_res(input int i, input int target);
      for (int n = 0; n < 200; n++) begin
         @(posedge clk);
         if (nres[i] >= target) break;
      end
      #1;
      chk("result_count", nres[i], target);
   endtask

   initial begin
      int   base;
      int   k;
      bit   seen;
      logic [7:0] w1_m [4];
      logic [7:0] w1_s [4];
      res_t       w1_e [4];

      for (int i = 0; i < 2; i++) begin
         busy[i] = 1'b0; acc[i] = 0; nres[i] = 0; exp_r[i] = '0; last_r[i] = '0;
      end
      rst_n = 1'b1;
      drive(0, 1'b0, 8'h00, 8'h00);
      drive(1, 1'b0, 8'h00, 8'h00);
      bus8.out_ready = 1'b1;
      bus1.out_ready = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Pin the model to hand-computed values.
      chk("pin_35_12", model(8, 8'h35, 8'h12), {8'h23, 1'b0, 1'b0});
      chk("pin_80_01", model(8, 8'h80, 8'h01), {8'h7F, 1'b0, 1'b1});
      chk("pin_7f_ff", model(8, 8'h7F, 8'hFF), {8'h80, 1'b1, 1'b1});
      chk("pin_w1_0_1", model(1, 8'h00, 8'h01), {8'h01, 1'b1, 1'b1});

      @(negedge clk);
      chk("post_reset_in_ready", bus8.in_ready, 32'd1);
      chk("post_reset_out_valid", bus8.out_valid, 32'd0);
      @(posedge clk);
      #1;

      send(0, 8'h35, 8'h12, 1'b1);
      k = acc_log.size() - 1;
      wait_res(0, 1);
      chk("lit_35_12", last_r[0], {8'h23, 1'b0, 1'b0});
      send(0, 8'h00, 8'h01, 1'b1); wait_res(0, 2);
      chk("lit_00_01", last_r[0], {8'hFF, 1'b1, 1'b0});
      send(0, 8'h80, 8'h01, 1'b1); wait_res(0, 3);
      chk("lit_80_01", last_r[0], {8'h7F, 1'b0, 1'b1});
      send(0, 8'h7F, 8'hFF, 1'b1); wait_res(0, 4);
      chk("lit_7f_ff", last_r[0], {8'h80, 1'b1, 1'b1});

      // Backpressure with a competing request that must wait.
      bus8.out_ready = 1'b0;
      send(0, 8'hFF, 8'hFF, 1'b0);
      drive(0, 1'b1, 8'hAA, 8'h55);
      seen = 1'b0;
      for (int n = 0; n < 64; n++) begin
         @(negedge clk);
         if (bus8.out_valid) begin seen = 1'b1; break; end
      end
      chk("bp_out_valid_seen", seen, 32'd1);
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         chk("bp_hold", {bus8.out_valid, bus8.in_ready, bus8.diff, bus8.borrow, bus8.ovf},
             {1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
      end
      @(posedge clk);
      #1 bus8.out_ready = 1'b1;
      send(0, 8'hAA, 8'h55, 1'b1);
      wait_res(0, 6);
      chk("lit_aa_55", last_r[0], {8'h55, 1'b0, 1'b1});

      // Back-to-back with in_valid held high.
      k = acc_log.size();
      send(0, 8'h01, 8'h02, 1'b0);
      send(0, 8'hC0, 8'h40, 1'b0);
      send(0, 8'h12, 8'h34, 1'b1);
      wait_res(0, 9);
      chk("lit_12_34", last_r[0], {8'hDE, 1'b1, 1'b0});
      chk("b2b_spacing_1", acc_log[k + 1] - acc_log[k], 32'd10);
      chk("b2b_spacing_2", acc_log[k + 2] - acc_log[k + 1], 32'd10);

      // Reset while RUN holds cnt=4.
      base = nres[0];
      send(0, 8'h33, 8'h11, 1'b1);
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_outputs", {bus8.out_valid, bus8.diff, bus8.borrow, bus8.ovf}, 32'd0);
      chk("abort_in_ready", bus8.in_ready, 32'd1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      chk("abort_no_result", nres[0], base);
      send(0, 8'h10, 8'h20, 1'b1);
      wait_res(0, base + 1);
      chk("lit_10_20", last_r[0], {8'hF0, 1'b1, 1'b0});

      // W=1 instance, all operand combinations.
      w1_m[0] = 8'd0; w1_s[0] = 8'd0; w1_e[0] = {8'd0, 1'b0, 1'b0};
      w1_m[1] = 8'd0; w1_s[1] = 8'd1; w1_e[1] = {8'd1, 1'b1, 1'b1};
      w1_m[2] = 8'd1; w1_s[2] = 8'd0; w1_e[2] = {8'd1, 1'b0, 1'b0};
      w1_m[3] = 8'd1; w1_s[3] = 8'd1; w1_e[3] = {8'd0, 1'b0, 1'b0};
      for (int c = 0; c < 4; c++) begin
         send(1, w1_m[c], w1_s[c], 1'b1);
         wait_res(1, c + 1);
         chk($sformatf("lit_w1_%0d", c), last_r[1], w1_e[c]);
      end

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
